// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: pipeline <-> interrupt controller handshake and system-register bus
interface intr_ctrl_if #(parameter int DBITS = 16, parameter int NSRC = 3);
  logic [NSRC-1:0]  irq;
  logic             intreq;
  logic             intack;
  logic [DBITS-1:0] retpc;
  logic             redir;
  logic [DBITS-1:0] redirpc;
  logic             reti;
  logic [2:0]       sraddr;
  logic [DBITS-1:0] srdout;
  logic             srwe;
  logic [2:0]       srwaddr;
  logic [DBITS-1:0] srdin;
  modport master (output irq, intack, retpc, reti, sraddr, srwe, srwaddr, srdin,
                  input intreq, redir, redirpc, srdout);
  modport slave  (input irq, intack, retpc, reti, sraddr, srwe, srwaddr, srdin,
                  output intreq, redir, redirpc, srdout);
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt prioritiser, entry handshake FSM and system-register file
module intr_ctrl #(
  parameter int               DBITS    = 16,
  parameter int               NSRC     = 3,
  parameter logic [DBITS-1:0] SIH_INIT = 16'h0010
) (
  input logic        clk,
  input logic        lock,
  intr_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, ENTER} state_t;
  state_t           state, state_n;
  logic             ie, oie, cm, om, ie_n, oie_n, cm_n, om_n;
  logic [DBITS-1:0] sih, sra, sii, sr0, sr1;
  logic [3:0]       num;
  logic             ack, ret;
  logic             we_scs, we_sih, we_sra, we_sii, we_sr0, we_sr1;
  assign ack    = state == REQ && bus.intack;
  assign ret    = bus.reti && (state == IDLE || (state == REQ && !bus.intack));
  assign we_scs = bus.srwe && bus.srwaddr == 3'd0;
  assign we_sih = bus.srwe && bus.srwaddr == 3'd1;
  assign we_sra = bus.srwe && bus.srwaddr == 3'd2;
  assign we_sii = bus.srwe && bus.srwaddr == 3'd3;
  assign we_sr0 = bus.srwe && bus.srwaddr == 3'd6;
  assign we_sr1 = bus.srwe && bus.srwaddr == 3'd7;
  always_comb begin
    num = 4'hF;
    for (int i = NSRC - 1; i >= 0; i--) if (bus.irq[i]) num = 4'(i + 1);
  end
  // Entry beats RETI, and RETI beats a concurrent SCS write
  always_comb begin
    {om_n, cm_n, oie_n, ie_n} = {om, cm, oie, ie};
    if (ack) {om_n, cm_n, oie_n, ie_n} = {cm, 1'b1, ie, 1'b0};
    else if (ret) {cm_n, ie_n} = {om, oie};
    else if (we_scs) {om_n, cm_n, oie_n, ie_n} = bus.srdin[3:0];
  end
  always_comb begin
    state_n = state == IDLE ? ((ie_n && |bus.irq) ? REQ : IDLE) :
              state == REQ  ? (ack ? ENTER : ie_n ? REQ : IDLE) : IDLE;
  end
  always_ff @(posedge clk or negedge lock) begin
    if (!lock) begin
      state                <= IDLE;
      {om, cm, oie, ie}    <= 4'b0100;
      sih                  <= SIH_INIT;
      sra                  <= '0;
      sii                  <= DBITS'(4'hF);
      sr0                  <= '0;
      sr1                  <= '0;
    end else begin
      state             <= state_n;
      {om, cm, oie, ie} <= {om_n, cm_n, oie_n, ie_n};
      if (we_sih) sih <= bus.srdin;
      if (ack) sra <= bus.retpc;
      else if (we_sra) sra <= bus.srdin;
      if (ack) sii <= DBITS'(num);
      else if (we_sii) sii <= bus.srdin;
      if (we_sr0) sr0 <= bus.srdin;
      if (we_sr1) sr1 <= bus.srdin;
    end
  end
  assign bus.intreq  = state == REQ;
  assign bus.redir   = state == ENTER;
  assign bus.redirpc = sih;
  assign bus.srdout  = bus.sraddr == 3'd0 ? {{(DBITS-4){1'b0}}, om, cm, oie, ie} :
                       bus.sraddr == 3'd1 ? sih :
                       bus.sraddr == 3'd2 ? sra :
                       bus.sraddr == 3'd3 ? sii :
                       bus.sraddr == 3'd6 ? sr0 :
                       bus.sraddr == 3'd7 ? sr1 : DBITS'(16'hFAFA);
endmodule
